adc_sample_sched: RTL

ADC_SAMPLE_SCHED -- requirements
Module: adc_sample_sched

---
 rtl/adc_sched_pkg.sv | 17 +
 rtl/adc_sample_sched_if.sv | 29 ++
 rtl/rr_arb2.sv | 31 +++
 rtl/adc_sample_sched.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/adc_sched_pkg.sv
// Shared types and constants for the ADC sample scheduler.
// Averaging depth applies only when ADC_AVG_EN is defined.
package adc_sched_pkg;

    localparam int ADC_W     = 12;
    localparam int AVG_N     = 4;
    localparam int AVG_SHIFT = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_CONVERT,
        ST_GAP,
        ST_DELIVER
    } state_e;

endpackage

// File: rtl/adc_sample_sched_if.sv
// Requester and ADC-controller signals of the sample scheduler.
// slave = scheduler side, master = requesters plus ADC controller.
interface adc_sample_sched_if;
    import adc_sched_pkg::*;

    logic [1:0]       req;
    logic             adc_finish;
    logic [12:0]      adc_data;
    logic             en_adc;
    logic [1:0]       grant;
    logic             rsp_valid;
    logic             rsp_id;
    logic [ADC_W-1:0] rsp_data;
    logic             busy;
    logic             timeout_err;

    modport slave (
        input  req, adc_finish, adc_data,
        output en_adc, grant, rsp_valid, rsp_id,
        output rsp_data, busy, timeout_err
    );

    modport master (
        output req, adc_finish, adc_data,
        input  en_adc, grant, rsp_valid, rsp_id,
        input  rsp_data, busy, timeout_err
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with a one-hot grant.
// The priority pointer moves past the requester that just finished.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    input  logic       i_last,
    output logic [1:0] o_gnt
);

    logic r_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (i_upd) begin
            r_ptr <= ~i_last;
        end
    end

    always_comb begin
        o_gnt = 2'b00;
        if (r_ptr) begin
            o_gnt = i_req[1] ? 2'b10 : {1'b0, i_req[0]};
        end else begin
            o_gnt = i_req[0] ? 2'b01 : {i_req[1], 1'b0};
        end
    end

endmodule

// File: rtl/adc_sample_sched.sv
// Schedules ADC conversions for two requesters with timeout and gap.
// Define ADC_AVG_EN to average AVG_N conversions per grant.
module adc_sample_sched
    import adc_sched_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int GAP_CYC     = 4
) (
    input  logic              clk,
    input  logic              rst,
    adc_sample_sched_if.slave sif
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int GW = $clog2(GAP_CYC + 1);

    state_e           r_state;
    logic [1:0]       r_pend;
    logic [1:0]       r_grant;
    logic [TW-1:0]    r_tmo;
    logic [GW-1:0]    r_gap;
    logic             r_rsp_id;
    logic [ADC_W-1:0] r_rsp_data;

    logic             w_tmo_hit;
    logic             w_fin;
    logic             w_gap_end;
    logic             w_deliver;
    logic             w_done;
    logic             w_more;
    logic [1:0]       w_arb_gnt;
    logic [ADC_W-1:0] w_result;
    logic             w_unused;

    assign w_tmo_hit = (r_state == ST_CONVERT)
                    && (r_tmo == TW'(TIMEOUT_CYC));
    assign w_fin     = (r_state == ST_CONVERT)
                    && sif.adc_finish && !w_tmo_hit;
    assign w_gap_end = (r_state == ST_GAP)
                    && (r_gap == GW'(GAP_CYC - 1));
    assign w_deliver = (r_state == ST_DELIVER);
    assign w_done    = w_deliver || w_tmo_hit;
    assign w_unused  = sif.adc_data[12];

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .i_req  (r_pend),
        .i_upd  (w_done),
        .i_last (r_grant[1]),
        .o_gnt  (w_arb_gnt)
    );

    // A new req in the finishing cycle re-arms the flag being cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~(w_done ? r_grant : 2'b00)) | sif.req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_tmo      <= '0;
            r_gap      <= '0;
            r_rsp_id   <= 1'b0;
            r_rsp_data <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (|r_pend) begin
                        r_state <= ST_GRANT;
                        r_grant <= w_arb_gnt;
                    end
                end
                ST_GRANT: begin
                    r_state <= ST_CONVERT;
                    r_tmo   <= '0;
                end
                ST_CONVERT: begin
                    if (w_tmo_hit) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                    end else if (w_fin) begin
                        r_state <= ST_GAP;
                        r_gap   <= '0;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                ST_GAP: begin
                    if (!w_gap_end) begin
                        r_gap <= r_gap + GW'(1);
                    end else if (w_more) begin
                        r_state <= ST_CONVERT;
                        r_tmo   <= '0;
                    end else begin
                        r_state    <= ST_DELIVER;
                        r_rsp_id   <= r_grant[1];
                        r_rsp_data <= w_result;
                    end
                end
                ST_DELIVER: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef ADC_AVG_EN
    localparam int CW = $clog2(AVG_N);

    logic [ADC_W+1:0] r_acc;
    logic [CW-1:0]    r_cnt;

    always_ff @(posedge clk) begin
        if (rst || r_state == ST_GRANT) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_fin) begin
            r_acc <= r_acc + {2'b00, sif.adc_data[ADC_W-1:0]};
        end else if (w_gap_end && w_more) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign w_more   = (r_cnt != CW'(AVG_N - 1));
    assign w_result = r_acc[ADC_W+1:AVG_SHIFT];
`else
    logic [ADC_W-1:0] r_sample;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample <= '0;
        end else if (w_fin) begin
            r_sample <= sif.adc_data[ADC_W-1:0];
        end
    end

    assign w_more   = 1'b0;
    assign w_result = r_sample;
`endif

    assign sif.en_adc      = (r_state == ST_CONVERT);
    assign sif.busy        = (r_state != ST_IDLE);
    assign sif.grant       = r_grant;
    assign sif.rsp_valid   = w_deliver;
    assign sif.rsp_id      = r_rsp_id;
    assign sif.rsp_data    = r_rsp_data;
    assign sif.timeout_err = w_tmo_hit;

endmodule
